// File: rtl/regfile_arbiter_if.sv
// Requester-side bus of the register-file arbiter: one instance per requester.
// The requester drives req/rw/addresses/data through the master modport and
// sees the grant and the registered read response; the arbiter uses slave.
interface regfile_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          req;
   logic          rw;      // 1 = write, 0 = read
   logic [AW-1:0] a1;
   logic [AW-1:0] a2;
   logic [AW-1:0] a3;
   logic [DW-1:0] wd;
   logic          gnt;     // combinational accept
   logic          rvalid;  // read response strobe, cycle after the grant
   logic [DW-1:0] rd1;
   logic [DW-1:0] rd2;

   modport master (
      output req, rw, a1, a2, a3, wd,
      input  gnt, rvalid, rd1, rd2
   );

   modport slave (
      input  req, rw, a1, a2, a3, wd,
      output gnt, rvalid, rd1, rd2
   );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the single-access register file between the core
// pipeline (r0) and the debug/loader port (r1). One grant per cycle,
// round-robin on ties; reads return one cycle later, steered to the owner.
// Optional build macro RFARB_X0_FILTER_EN: writes to x0 are swallowed
// (granted, WE3 held low) and operands read from x0 are forced to zero.
module regfile_arbiter #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_arbiter_if.slave     r0,
   regfile_arbiter_if.slave     r1,
   output logic [AW-1:0]        A1,
   output logic [AW-1:0]        A2,
   output logic [AW-1:0]        A3,
   output logic [DW-1:0]        WD3,
   output logic                 WE3,
   input  logic [DW-1:0]        RD1,
   input  logic [DW-1:0]        RD2
);

   // last: index of the most recently granted requester (1 after reset so
   // requester 0 wins the first tie). rpend/rown: a read was issued last
   // cycle and who owns its response.
   logic          last;
   logic          rpend;
   logic          rown;

   logic          g0, g1;
   logic          any_gnt;
   logic          rd_gnt;
   logic          wr_gnt;
   logic          s_rw;
   logic [AW-1:0] s_a1, s_a2, s_a3;
   logic [DW-1:0] s_wd;
   logic [DW-1:0] rsp1, rsp2;

   // Round-robin pick; nothing is granted while reset is held
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (!reset) begin
         if (r0.req && r1.req) begin
            g0 = last;
            g1 = ~last;
         end else begin
            g0 = r0.req;
            g1 = r1.req;
         end
      end
   end

   assign r0.gnt  = g0;
   assign r1.gnt  = g1;
   assign any_gnt = g0 | g1;

   // Select the winning requester's operands
   always_comb begin
      s_rw = r0.rw;
      s_a1 = r0.a1;
      s_a2 = r0.a2;
      s_a3 = r0.a3;
      s_wd = r0.wd;
      if (g1) begin
         s_rw = r1.rw;
         s_a1 = r1.a1;
         s_a2 = r1.a2;
         s_a3 = r1.a3;
         s_wd = r1.wd;
      end
   end

   assign rd_gnt = any_gnt & ~s_rw;
   assign wr_gnt = any_gnt &  s_rw;

   // Register-file drive; idle cycles present all-zero (a harmless x0 read)
   always_comb begin
      A1  = rd_gnt ? s_a1 : '0;
      A2  = rd_gnt ? s_a2 : '0;
      A3  = wr_gnt ? s_a3 : '0;
      WD3 = wr_gnt ? s_wd : '0;
`ifdef RFARB_X0_FILTER_EN
      WE3 = wr_gnt && (s_a3 != '0);
`else
      WE3 = wr_gnt;
`endif
   end

   // Priority pointer and read-pending tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last  <= 1'b1;
         rpend <= 1'b0;
         rown  <= 1'b0;
      end else begin
         if (any_gnt)
            last <= g1;
         // A read granted this cycle keeps the pipe full; otherwise it drains
         rpend <= rd_gnt;
         if (rd_gnt)
            rown <= g1;
      end
   end

`ifdef RFARB_X0_FILTER_EN
   logic z1, z2;

   // Remember which operands of the issued read addressed x0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         z1 <= 1'b0;
         z2 <= 1'b0;
      end else if (rd_gnt) begin
         z1 <= (s_a1 == '0);
         z2 <= (s_a2 == '0);
      end
   end

   assign rsp1 = z1 ? '0 : RD1;
   assign rsp2 = z2 ? '0 : RD2;
`else
   assign rsp1 = RD1;
   assign rsp2 = RD2;
`endif

   // Steer the response to its owner; the other requester sees zeros
   always_comb begin
      r0.rvalid = rpend & ~rown;
      r1.rvalid = rpend &  rown;
      r0.rd1    = (rpend & ~rown) ? rsp1 : '0;
      r0.rd2    = (rpend & ~rown) ? rsp2 : '0;
      r1.rd1    = (rpend &  rown) ? rsp1 : '0;
      r1.rd2    = (rpend &  rown) ? rsp2 : '0;
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed vector table, reset/x0 sequences, then
// randomized traffic checked against a rule-level model with a shadow regfile.
module tb_regfile_arbiter;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NV = 12;
`ifdef RFARB_X0_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   typedef struct {
      logic          req;
      logic          rw;
      logic [AW-1:0] a1, a2, a3;
      logic [DW-1:0] wd;
   } rq_t;

   typedef struct {
      rq_t           q0, q1;
      logic          g0, g1, we, v0, v1;
      logic [DW-1:0] d10, d20, d11, d21;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] A1, A2, A3;
   logic [DW-1:0] WD3, RD1, RD2;
   logic          WE3;
   logic [DW-1:0] mem [32] = '{default: '0};

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_arbiter_if #(.AW(AW), .DW(DW)) i0 ();
   regfile_arbiter_if #(.AW(AW), .DW(DW)) i1 ();

   regfile_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .r0(i0), .r1(i1),
      .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3), .RD1(RD1), .RD2(RD2)
   );

   // Register file stub: synchronous write, registered read
   always @(posedge clk) begin
      if (WE3) mem[A3] <= WD3;
      RD1 <= mem[A1];
      RD2 <= mem[A2];
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic rq_t idle();
      rq_t r;
      r.req = 1'b0; r.rw = 1'b0; r.a1 = '0; r.a2 = '0; r.a3 = '0; r.wd = '0;
      return r;
   endfunction

   function automatic rq_t rd(input int x1, input int x2);
      rq_t r = idle();
      r.req = 1'b1; r.a1 = AW'(x1); r.a2 = AW'(x2);
      return r;
   endfunction

   function automatic rq_t wr(input int x3, input logic [DW-1:0] d);
      rq_t r = idle();
      r.req = 1'b1; r.rw = 1'b1; r.a3 = AW'(x3); r.wd = d;
      return r;
   endfunction

   function automatic vec_t mk(input rq_t a, input rq_t b,
                               input logic g0, input logic g1, input logic we,
                               input logic v0, input logic v1,
                               input logic [DW-1:0] d10, input logic [DW-1:0] d20,
                               input logic [DW-1:0] d11, input logic [DW-1:0] d21);
      vec_t v;
      v.q0 = a; v.q1 = b; v.g0 = g0; v.g1 = g1; v.we = we; v.v0 = v0; v.v1 = v1;
      v.d10 = d10; v.d20 = d20; v.d11 = d11; v.d21 = d21;
      return v;
   endfunction

   task automatic setq(input rq_t a, input rq_t b);
      i0.req = a.req; i0.rw = a.rw; i0.a1 = a.a1; i0.a2 = a.a2; i0.a3 = a.a3; i0.wd = a.wd;
      i1.req = b.req; i1.rw = b.rw; i1.a1 = b.a1; i1.a2 = b.a2; i1.a3 = b.a3; i1.wd = b.wd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   vec_t          tv [NV];
   rq_t           q [2];
   bit            held [2];
   bit            mlast, pv, pown;
   logic [DW-1:0] pd1, pd2;
   logic [DW-1:0] sh [32];
   int            eg;
   logic          ewe;

   initial begin
      // Directed vectors; outputs are sampled mid-cycle of each row
      tv[0]  = mk(wr(3, 32'h11), idle(),       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
      tv[1]  = mk(wr(4, 32'h22), idle(),       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
      tv[2]  = mk(rd(3, 4),      idle(),       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
      tv[3]  = mk(idle(),        idle(),       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11, 32'h22, 0, 0);
      tv[4]  = mk(rd(3, 4),      rd(4, 3),     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
      tv[5]  = mk(rd(3, 4),      rd(4, 3),     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 32'h22, 32'h11);
      tv[6]  = mk(rd(3, 4),      rd(4, 3),     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11, 32'h22, 0, 0);
      tv[7]  = mk(rd(3, 4),      rd(4, 3),     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 32'h22, 32'h11);
      tv[8]  = mk(idle(),        wr(5, 32'hDEAD), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11, 32'h22, 0, 0);
      tv[9]  = mk(rd(5, 0),      idle(),       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
      tv[10] = mk(idle(),        idle(),       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD, 0, 0, 0);
      tv[11] = mk(idle(),        idle(),       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);

      // Reset with live requests: nothing may be granted or driven
      reset = 1'b1;
      setq(wr(3, 32'h11), rd(1, 2));
      @(negedge clk);
      chk1("rst gnt0", i0.gnt, 1'b0);
      chk1("rst gnt1", i1.gnt, 1'b0);
      chk1("rst we3", WE3, 1'b0);
      chk32("rst a3", {27'b0, A3}, 0);
      chk32("rst wd3", WD3, 0);
      chk32("rst a1", {27'b0, A1}, 0);
      chk1("rst rvalid0", i0.rvalid, 1'b0);
      chk1("rst rvalid1", i1.rvalid, 1'b0);
      chk32("rst rd1_1", i1.rd1, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         setq(tv[i].q0, tv[i].q1);
         @(negedge clk);
         chk1($sformatf("v%0d gnt0", i), i0.gnt, tv[i].g0);
         chk1($sformatf("v%0d gnt1", i), i1.gnt, tv[i].g1);
         chk1($sformatf("v%0d we3", i), WE3, tv[i].we);
         chk1($sformatf("v%0d rvalid0", i), i0.rvalid, tv[i].v0);
         chk1($sformatf("v%0d rvalid1", i), i1.rvalid, tv[i].v1);
         chk32($sformatf("v%0d rd1_0", i), i0.rd1, tv[i].d10);
         chk32($sformatf("v%0d rd2_0", i), i0.rd2, tv[i].d20);
         chk32($sformatf("v%0d rd1_1", i), i1.rd1, tv[i].d11);
         chk32($sformatf("v%0d rd2_1", i), i1.rd2, tv[i].d21);
         next_cycle();
      end

      // Reset lands the cycle after a granted read: response must vanish,
      // and the pointer returns to favouring requester 0
      setq(rd(3, 4), idle());
      @(negedge clk);
      chk1("pend gnt0", i0.gnt, 1'b1);
      next_cycle();
      reset = 1'b1;
      setq(rd(3, 4), rd(4, 3));
      @(negedge clk);
      chk1("pend rst rvalid0", i0.rvalid, 1'b0);
      chk1("pend rst gnt0", i0.gnt, 1'b0);
      chk1("pend rst gnt1", i1.gnt, 1'b0);
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk1("post rst rvalid0", i0.rvalid, 1'b0);
      chk1("post rst rvalid1", i1.rvalid, 1'b0);
      chk1("post rst tie gnt0", i0.gnt, 1'b1);
      chk1("post rst tie gnt1", i1.gnt, 1'b0);
      next_cycle();

      // Write to x0 then read it back
      setq(wr(0, 32'hFFFF), idle());
      @(negedge clk);
      chk1("x0 wr gnt0", i0.gnt, 1'b1);
      chk1("x0 wr we3", WE3, !FILT);
      next_cycle();
      setq(rd(0, 3), idle());
      @(negedge clk);
      chk1("x0 rd gnt0", i0.gnt, 1'b1);
      next_cycle();
      setq(idle(), idle());
      @(negedge clk);
      chk1("x0 rd rvalid0", i0.rvalid, 1'b1);
      chk32("x0 rd1_0", i0.rd1, FILT ? 32'h0 : 32'hFFFF);
      chk32("x0 rd2_0", i0.rd2, 32'h11);
      next_cycle();

      // Fresh reset before random traffic
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;

      // Shadow starts from the stub's contents; afterwards it evolves only
      // by the model's own rules
      sh    = mem;
      mlast = 1'b1;
      pv    = 1'b0;
      pown  = 1'b0;
      pd1   = '0;
      pd2   = '0;
      held[0] = 1'b0;
      held[1] = 1'b0;
      q[0] = idle();
      q[1] = idle();
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!held[k]) begin
               q[k].req = ($urandom % 4) != 0;
               q[k].rw  = 1'($urandom % 2);
               q[k].a1  = AW'($urandom_range(0, 7));
               q[k].a2  = AW'($urandom_range(0, 7));
               q[k].a3  = AW'($urandom_range(0, 7));
               q[k].wd  = $urandom;
            end
         end
         setq(q[0], q[1]);
         @(negedge clk);
         if (q[0].req && q[1].req) eg = mlast ? 0 : 1;
         else if (q[0].req)        eg = 0;
         else if (q[1].req)        eg = 1;
         else                      eg = -1;
         ewe = (eg >= 0) && q[eg].rw && !(FILT && q[eg].a3 == '0);
         chk1("rnd gnt0", i0.gnt, eg == 0);
         chk1("rnd gnt1", i1.gnt, eg == 1);
         chk1("rnd we3", WE3, ewe);
         chk1("rnd rvalid0", i0.rvalid, pv && !pown);
         chk1("rnd rvalid1", i1.rvalid, pv && pown);
         chk32("rnd rd1_0", i0.rd1, (pv && !pown) ? pd1 : 32'h0);
         chk32("rnd rd2_0", i0.rd2, (pv && !pown) ? pd2 : 32'h0);
         chk32("rnd rd1_1", i1.rd1, (pv && pown) ? pd1 : 32'h0);
         chk32("rnd rd2_1", i1.rd2, (pv && pown) ? pd2 : 32'h0);
         pv = 1'b0;
         if (eg >= 0) begin
            mlast = (eg == 1);
            if (q[eg].rw) begin
               if (ewe) sh[q[eg].a3] = q[eg].wd;
            end else begin
               pv   = 1'b1;
               pown = (eg == 1);
               pd1  = (FILT && q[eg].a1 == '0) ? 32'h0 : sh[q[eg].a1];
               pd2  = (FILT && q[eg].a2 == '0) ? 32'h0 : sh[q[eg].a2];
            end
         end
         held[0] = q[0].req && (eg != 0);
         held[1] = q[1].req && (eg != 1);
         next_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester arbiter that shares the single-access-per-cycle register file between the core pipeline (requester 0) and the debug/loader port (requester 1). Each cycle it grants at most one request, round-robin, and drives the register file's A1/A2/A3/WD3/WE3. Read data from the register file arrives one cycle later and is routed back to the granted requester with a valid strobe. It sits directly in front of the register file; the register file's own ports are driven only by this block.

## Interface
- AW, 5, register address width
- DW, 32, data width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0 / req1  input  1  request from requester 0 / 1
- rw0 / rw1  input  1  1 = write, 0 = read
- a1_0, a2_0 / a1_1, a2_1  input  AW  read addresses
- a3_0 / a3_1  input  AW  write address
- wd0 / wd1  input  DW  write data
- gnt0 / gnt1  output  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  output  1  read data valid for requester (registered)
- rd1_0, rd2_0 / rd1_1, rd2_1  output  DW  read data to requester
- A1, A2, A3  output  AW  to register file
- WD3  output  DW  to register file
- WE3  output  1  to register file
- RD1, RD2  input  DW  from register file (registered read, valid cycle after issue)

## Operation
- One clock (clk); asynchronous, active-high reset (reset).
- State: priority pointer `last` (which requester was last granted), read-pending flag `rpend`, read-owner bit `rown`.
- Arbitration per cycle: only req0 → grant 0; only req1 → grant 1; both → grant the requester ≠ `last`; neither → no grant.
- At most one of gnt0/gnt1 is high. A requester holds req and its operands stable until it sees gnt.
- `last` updates to the granted index on every grant; it is unchanged in idle cycles.
- Granted write: A3 = a3_x, WD3 = wdx, WE3 = 1.
- Granted read: A1 = a1_x, A2 = a2_x, WE3 = 0. Sets rpend = 1 and rown = x at the edge.
- Idle cycle: WE3 = 0, A1/A2/A3/WD3 = 0. An idle cycle therefore also performs a harmless read of x0.
- Response: in the cycle after a granted read, rvalid_rown = 1 and rd1_rown/rd2_rown = RD1/RD2. The other requester's rd outputs are 0. rpend clears unless a new read is granted in that same cycle.
- Back-to-back reads are fully pipelined: one grant per cycle, one response per cycle.
- A write followed by a read of the same address in the next cycle returns the new value. No forwarding is needed.

## Timing
- Grant latency: 0 cycles (combinational from req, rw, and `last`).
- Read latency: 1 cycle from gnt to rvalid.
- Write takes effect at the edge that ends the grant cycle.
- Reset values: `last` = 1 (requester 0 wins the first tie), rpend = 0, rown = 0, rvalid0/1 = 0, rd outputs = 0.
- Reset asserted while a read is pending: the response is dropped and no rvalid is issued after reset release.
- Gnt and the register-file drive outputs are 0 while reset is high.

## Configuration
- RFARB_X0_FILTER_EN defined:
  - A granted write with a3 = 0 is still granted, but WE3 stays 0.
  - A granted read returns 0 on any operand whose address was 0, regardless of RD1/RD2.
  - The block tracks this with two registered zero flags per response.
- RFARB_X0_FILTER_EN undefined: addresses and data pass through unfiltered.

## Test plan
- Reset, then req0 reads A1=3, A2=4 after prior writes of 0x11 and 0x22 → gnt0 in the same cycle; next cycle rvalid0 = 1, rd1_0 = 0x11, rd2_0 = 0x22.
- req0 and req1 both held for 4 cycles → grants alternate 0, 1, 0, 1 and gnt0 & gnt1 is never 1.
- req1 writes x5 = 0xDEAD in cycle N; req0 reads A1 = 5 in cycle N+1 → rvalid0 in cycle N+2 with rd1_0 = 0xDEAD.
- Alternating read(1), read(0), read(1) with continuous requests → three consecutive rvalid pulses, each steered to the correct owner; the other owner's rd outputs stay 0.
- reset asserted the cycle after a granted read → no rvalid appears after release, and `last` resets so req0 wins the first tie.
- With RFARB_X0_FILTER_EN: write 0xFFFF to a3 = 0 → WE3 = 0; a subsequent read of A1 = 0 returns 0. Without the macro, WE3 = 1 for that write.
